fetch_unit: RTL and testbench

- Instruction-fetch front end that consumes the program counter and controls when it advances.
- Reads `pcCur`, issues a request/acknowledge read to instruction memory, and holds the returned word in an instruction register until decode accepts it.
- Drives the PC's `nextInst` and `pcWrite` inputs, and sequences jump redirects requested by the controller.
- Sits between the PC block and decode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/register_component.sv | 20 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding
// and default geometry of the PC / instruction path.
package fetch_pkg;

    typedef enum logic [2:0] {
        INIT0  = 3'd0,
        INIT1  = 3'd1,
        SETTLE = 3'd2,
        REQ    = 3'd3,
        VALID  = 3'd4,
        DRAIN  = 3'd5,
        REDIR  = 3'd6
    } fetch_state_t;

    localparam int          WIDTH_DEF     = 16;
    localparam int          PC_INC_DEF    = 2;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam int          MIN_PC_SETTLE = 2;

endpackage

// File: rtl/register_component.sv
// Generic enable-gated register with synchronous active-high clear.
module register_component #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (write) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequences PC writes, issues req/ack reads to
// instruction memory and holds the fetched word until decode accepts it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter int               PC_INC    = PC_INC_DEF,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF),
    parameter int               PC_SETTLE = MIN_PC_SETTLE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pcCur,
    output logic [WIDTH-1:0] nextInst,
    output logic             pcWrite,
    input  logic             flush,
    output logic             memReq,
    output logic [WIDTH-1:0] memAddr,
    input  logic             memAck,
    input  logic [WIDTH-1:0] memData,
    output logic             instValid,
    output logic [WIDTH-1:0] instOut,
    output logic [WIDTH-1:0] instPc,
    input  logic             decodeReady
);

    localparam int CNT_W = $clog2(PC_SETTLE + 1);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic             settle_done;
    logic             capture;

    assign settle_done = (settle_cnt == CNT_W'(PC_SETTLE - 1));
    assign capture     = (state == REQ) && memAck && !flush;

    // The PC mux samples nextInst a cycle ahead of the PC write, so the
    // reset address must already be presented during INIT0.
    assign nextInst = ((state == INIT0) || (state == INIT1)) ? RESET_PC
                                                              : pcCur + WIDTH'(PC_INC);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT0:   state_next = flush ? REDIR : INIT1;
            INIT1:   state_next = flush ? REDIR : SETTLE;
            SETTLE: begin
                if (flush) begin
                    state_next = REDIR;
                end else if (settle_done) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (memAck) begin
                    state_next = flush ? REDIR : VALID;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            VALID: begin
                if (flush) begin
                    state_next = REDIR;
                end else if (decodeReady) begin
                    state_next = SETTLE;
                end
            end
            // The outstanding read must complete before the redirect write.
            DRAIN:   state_next = memAck ? REDIR : DRAIN;
            REDIR:   state_next = flush ? REDIR : SETTLE;
            default: state_next = INIT0;
        endcase
    end

    always_comb begin
        memReq    = 1'b0;
        pcWrite   = 1'b0;
        instValid = 1'b0;
        case (state)
            INIT1, REDIR: pcWrite = 1'b1;
            REQ, DRAIN:   memReq  = 1'b1;
            VALID: begin
                instValid = 1'b1;
                pcWrite   = decodeReady && !flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if ((state == SETTLE) && !flush && !settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Address is captured on the SETTLE->REQ transition and then frozen for
    // the whole request, including any drain after a flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            memAddr <= '0;
        end else if ((state == SETTLE) && !flush && settle_done) begin
            memAddr <= pcCur;
        end
    end

    register_component #(.WIDTH(WIDTH)) inst_reg (
        .clock (clock),
        .reset (reset),
        .write (capture),
        .d     (memData),
        .q     (instOut)
    );

    register_component #(.WIDTH(WIDTH)) inst_pc_reg (
        .clock (clock),
        .reset (reset),
        .write (capture),
        .d     (memAddr),
        .q     (instPc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC/mux environment model, scripted memory responses and
// a scoreboard of fetched (pc, instruction) pairs.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } fetch_t;

    logic        clock;
    logic        reset;
    logic [15:0] pcCur;
    logic [15:0] nextInst;
    logic        pcWrite;
    logic        flush;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic        instValid;
    logic [15:0] instOut;
    logic [15:0] instPc;
    logic        decodeReady;

    logic        pcSrc;
    logic [15:0] jumpAddr;
    logic [15:0] mux_q;
    logic        valid_d;

    fetch_t exp_q[$];
    int     n_pass;
    int     n_total;

    fetch_unit #(
        .WIDTH     (16),
        .PC_INC    (2),
        .RESET_PC  (16'h0000),
        .PC_SETTLE (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pcCur       (pcCur),
        .nextInst    (nextInst),
        .pcWrite     (pcWrite),
        .flush       (flush),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memData     (memData),
        .instValid   (instValid),
        .instOut     (instOut),
        .instPc      (instPc),
        .decodeReady (decodeReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // PC block model: mux register samples every cycle, PC captures on pcWrite.
    always @(posedge clock) begin
        if (reset) begin
            mux_q <= 16'h5A5A;
            pcCur <= 16'h5A5A;
        end else begin
            mux_q <= pcSrc ? jumpAddr : nextInst;
            if (pcWrite) pcCur <= mux_q;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", tag, got, want);
        end
    endtask

    // Scoreboard: every newly presented instruction must match the oldest served one.
    always @(negedge clock) begin
        if (reset) begin
            valid_d = 1'b0;
        end else begin
            if (instValid && !valid_d) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    fetch_t e;
                    e = exp_q.pop_front();
                    check("sb_instPc", instPc, e.pc);
                    check("sb_instOut", instOut, e.inst);
                end
            end
            valid_d = instValid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_init_seq();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            #1;
            check("init_pcWrite", pcWrite, c == 1);
            check("init_memReq", memReq, c == 4);
            check("init_instValid", instValid, 0);
            if (c == 1) check("init_nextInst", nextInst, 16'h0000);
        end
        check("init_memAddr", memAddr, 16'h0000);
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!memReq && n < budget) begin
            tick();
            #1;
            n++;
        end
        check("req_reached", memReq, 1);
    endtask

    task automatic serve(input int waits, input logic [15:0] data, input logic [15:0] pc);
        fetch_t e;
        for (int i = 0; i < waits; i++) begin
            check("serve_memReq", memReq, 1);
            check("serve_memAddr", memAddr, pc);
            tick();
            #1;
        end
        memAck  = 1'b1;
        memData = data;
        e.pc    = pc;
        e.inst  = data;
        exp_q.push_back(e);
        #1;
        check("ack_instValid", instValid, 0);
        tick();
        memAck = 1'b0;
        #1;
        check("fetch_instValid", instValid, 1);
        check("fetch_memReq", memReq, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within budget");
        $fatal(1);
    end

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        memAck      = 1'b0;
        memData     = 16'h0000;
        decodeReady = 1'b0;
        pcSrc       = 1'b0;
        jumpAddr    = 16'h0000;

        repeat (3) @(posedge clock);
        #2;
        check("rst_memReq", memReq, 0);
        check("rst_pcWrite", pcWrite, 0);
        check("rst_instValid", instValid, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_instOut", instOut, 0);
        check("rst_instPc", instPc, 0);
        reset = 1'b0;
        check_init_seq();

        // first fetch with three wait cycles
        serve(3, 16'hABCD, 16'h0000);
        check("fetch0_instOut", instOut, 16'hABCD);
        check("fetch0_instPc", instPc, 16'h0000);

        // decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            check("hold_instOut", instOut, 16'hABCD);
            check("hold_pcWrite", pcWrite, 0);
            check("hold_instValid", instValid, 1);
            tick();
            #1;
        end
        decodeReady = 1'b1;
        #1;
        check("adv_pcWrite", pcWrite, 1);
        check("adv_nextInst", nextInst, 16'h0002);
        tick();
        decodeReady = 1'b0;
        #1;
        check("adv_instValid", instValid, 0);
        check("adv_pcWrite_once", pcWrite, 0);
        wait_req(20);
        check("adv_memAddr", memAddr, 16'h0002);
        serve(0, 16'h1111, 16'h0002);

        // flush beats decodeReady in VALID; redirect to FFFE
        decodeReady = 1'b1;
        flush       = 1'b1;
        pcSrc       = 1'b1;
        jumpAddr    = 16'hFFFE;
        #1;
        check("fd_pcWrite", pcWrite, 0);
        tick();
        flush       = 1'b0;
        decodeReady = 1'b0;
        #1;
        check("fd_redir_pcWrite", pcWrite, 1);
        check("fd_instValid", instValid, 0);
        tick();
        pcSrc = 1'b0;
        #1;
        check("fd_pcWrite_once", pcWrite, 0);
        wait_req(20);
        check("jump_memAddr", memAddr, 16'hFFFE);
        serve(1, 16'h2222, 16'hFFFE);

        // wrap-around of the sequential PC
        decodeReady = 1'b1;
        #1;
        check("wrap_nextInst", nextInst, 16'h0000);
        check("wrap_pcWrite", pcWrite, 1);
        tick();
        decodeReady = 1'b0;
        wait_req(20);
        check("wrap_memAddr", memAddr, 16'h0000);

        // flush in REQ, ack arrives two cycles later and is discarded
        flush    = 1'b1;
        pcSrc    = 1'b1;
        jumpAddr = 16'h0100;
        #1;
        check("drain_req0", memReq, 1);
        tick();
        flush = 1'b0;
        #1;
        check("drain_req1", memReq, 1);
        check("drain_valid1", instValid, 0);
        check("drain_pcWrite1", pcWrite, 0);
        tick();
        #1;
        check("drain_req2", memReq, 1);
        check("drain_addr", memAddr, 16'h0000);
        memAck  = 1'b1;
        memData = 16'hDEAD;
        #1;
        check("drain_pcWrite2", pcWrite, 0);
        tick();
        memAck = 1'b0;
        #1;
        check("drain_redir_pcWrite", pcWrite, 1);
        check("drain_memReq", memReq, 0);
        check("drain_instValid", instValid, 0);
        tick();
        pcSrc = 1'b0;
        wait_req(20);
        check("drain_jump_memAddr", memAddr, 16'h0100);
        serve(0, 16'h3333, 16'h0100);
        decodeReady = 1'b1;
        #1;
        tick();
        decodeReady = 1'b0;
        wait_req(20);
        check("seq_memAddr", memAddr, 16'h0102);

        // flush together with ack in REQ
        memAck   = 1'b1;
        memData  = 16'hBEEF;
        flush    = 1'b1;
        pcSrc    = 1'b1;
        jumpAddr = 16'h0200;
        #1;
        tick();
        memAck = 1'b0;
        flush  = 1'b0;
        #1;
        check("fa_pcWrite", pcWrite, 1);
        check("fa_instValid", instValid, 0);
        check("fa_memReq", memReq, 0);
        tick();
        pcSrc = 1'b0;
        wait_req(20);
        check("fa_memAddr", memAddr, 16'h0200);

        // reset in the middle of a request
        reset = 1'b1;
        #1;
        tick();
        check("rreq_memReq", memReq, 0);
        reset = 1'b0;
        check_init_seq();
        serve(0, 16'h4444, 16'h0000);
        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
